// File: rtl/print_line_collector_pkg.sv
// Shared constants and types for the print line collector.
// RULE_DETECT_EN (optional define) enables rule-line detection in the top level.
package print_line_collector_pkg;

    localparam int PRINT_LINE_LEN = 76;

    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_DASH   = 8'h2D;
    localparam logic [7:0] CH_LOWBAR = 8'h5F;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } line_col_state_t;

    function automatic logic is_rule_char(input logic [7:0] c);
        return (c == CH_STAR) || (c == CH_DASH) || (c == CH_LOWBAR);
    endfunction

endpackage

// File: rtl/print_line_collector_line_buf_mem.sv
// Line character storage: DEPTH x 8, one write port, registered read port.
// Out-of-range read addresses return zero; the caller masks them anyway.
module line_buf_mem #(
    parameter int DEPTH = 76,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (int'(raddr) < DEPTH) begin
            rdata_q <= mem_q[raddr];
        end else begin
            rdata_q <= 8'h00;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/print_line_collector.sv
// Collects an ASCII byte stream into LF- or width-terminated lines behind a random-access read port.
// Define RULE_DETECT_EN to flag lines made entirely of one of '*', '-', '_'.
module print_line_collector
    import print_line_collector_pkg::*;
#(
    parameter int  LINE_LEN     = PRINT_LINE_LEN,
    parameter int  RULE_MIN_LEN = 8,
    localparam int LEN_W        = $clog2(LINE_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ch_valid,
    input  logic [7:0]       ch_data,
    output logic             ch_ready,
    output logic             line_valid,
    output logic [LEN_W-1:0] line_len,
    output logic             line_wrapped,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    input  logic             line_ack,
    output logic             line_rule,
    output logic [7:0]       line_rule_ch
);

    line_col_state_t  state_q, state_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             wrapped_q, wrapped_d;
    logic             ready_q, ready_d;
    logic             rd_valid_q;
    logic             rd_hit_q;
    logic             mem_we;
    logic             accept;
    logic [7:0]       mem_rdata;

    // ready_q is a registered copy of "next state is FILL", so it stays low
    // for the first cycle after reset release and the cycle after completion.
    assign accept = ch_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        wrapped_d = wrapped_q;
        mem_we    = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (ch_data == CH_LF) begin
                        len_d     = wr_ptr_q;
                        wrapped_d = 1'b0;
                        state_d   = HOLD;
                    end else if (ch_data != CH_CR) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_ptr_q == LEN_W'(LINE_LEN - 1)) begin
                            len_d     = LEN_W'(LINE_LEN);
                            wrapped_d = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (line_ack) begin
                    state_d  = FILL;
                    wr_ptr_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
        ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            len_q      <= '0;
            wrapped_q  <= 1'b0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            len_q      <= len_d;
            wrapped_q  <= wrapped_d;
            ready_q    <= ready_d;
            rd_valid_q <= 1'b1;
            rd_hit_q   <= (rd_addr < len_q);
        end
    end

    line_buf_mem #(
        .DEPTH (LINE_LEN),
        .AW    (LEN_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (ch_data),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    assign ch_ready     = ready_q;
    assign line_valid   = (state_q == HOLD);
    assign line_len     = len_q;
    assign line_wrapped = wrapped_q;
    // rd_valid_q keeps rd_data at zero until the first read after reset.
    assign rd_data      = !rd_valid_q ? 8'h00 : (rd_hit_q ? mem_rdata : CH_SP);

`ifdef RULE_DETECT_EN
    logic       rule_ok_q, rule_ok_d;
    logic [7:0] first_ch_q, first_ch_d;
    logic       line_rule_q, line_rule_d;
    logic [7:0] rule_ch_q, rule_ch_d;

    always_comb begin
        rule_ok_d   = rule_ok_q;
        first_ch_d  = first_ch_q;
        line_rule_d = line_rule_q;
        rule_ch_d   = rule_ch_q;
        if (mem_we) begin
            if (wr_ptr_q == '0) begin
                rule_ok_d  = is_rule_char(ch_data);
                first_ch_d = ch_data;
            end else begin
                rule_ok_d = rule_ok_q && (ch_data == first_ch_q);
            end
        end
        if (state_q == FILL && state_d == HOLD) begin
            if (rule_ok_d && (len_d >= LEN_W'(RULE_MIN_LEN))) begin
                line_rule_d = 1'b1;
                rule_ch_d   = first_ch_d;
            end else begin
                line_rule_d = 1'b0;
                rule_ch_d   = 8'h00;
            end
        end else if (state_q == HOLD && line_ack) begin
            line_rule_d = 1'b0;
            rule_ch_d   = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rule_ok_q   <= 1'b0;
            first_ch_q  <= 8'h00;
            line_rule_q <= 1'b0;
            rule_ch_q   <= 8'h00;
        end else begin
            rule_ok_q   <= rule_ok_d;
            first_ch_q  <= first_ch_d;
            line_rule_q <= line_rule_d;
            rule_ch_q   <= rule_ch_d;
        end
    end

    assign line_rule    = line_rule_q;
    assign line_rule_ch = rule_ch_q;
`else
    assign line_rule    = 1'b0;
    assign line_rule_ch = 8'h00;
`endif

endmodule

// File: tb/tb_print_line_collector.sv
// Self-checking bench for print_line_collector: directed line patterns plus a random-gap stream.
// Works with or without RULE_DETECT_EN defined.
module tb_print_line_collector;

    localparam int LINE_LEN = 76;
    localparam int LEN_W    = $clog2(LINE_LEN + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ch_valid = 1'b0;
    logic [7:0]       ch_data = 8'h00;
    logic             ch_ready;
    logic             line_valid;
    logic [LEN_W-1:0] line_len;
    logic             line_wrapped;
    logic [LEN_W-1:0] rd_addr = '0;
    logic [7:0]       rd_data;
    logic             line_ack = 1'b0;
    logic             line_rule;
    logic [7:0]       line_rule_ch;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model state: what has been accepted and which line is on show.
    logic       m_en = 1'b0;
    logic       m_hold = 1'b0;
    logic       m_wrapped = 1'b0;
    logic       m_acc = 1'b0;
    logic [7:0] cur[$];
    logic [7:0] m_line[$];
    int         src_chars = 0;
    int         rx_total = 0;
    int         line_no = 0;

    print_line_collector dut (
        .clk          (clk),
        .rst          (rst),
        .ch_valid     (ch_valid),
        .ch_data      (ch_data),
        .ch_ready     (ch_ready),
        .line_valid   (line_valid),
        .line_len     (line_len),
        .line_wrapped (line_wrapped),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .line_ack     (line_ack),
        .line_rule    (line_rule),
        .line_rule_ch (line_rule_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_rule_ch(input logic [7:0] q[$]);
`ifdef RULE_DETECT_EN
        logic [7:0] c;
        if (q.size() < 8) return 8'h00;
        c = q[0];
        if (!(c == 8'h2A || c == 8'h2D || c == 8'h5F)) return 8'h00;
        foreach (q[i]) if (q[i] != c) return 8'h00;
        return c;
`else
        return (q.size() > 1000) ? 8'h01 : 8'h00;
`endif
    endfunction

    task automatic model_reset();
        m_en = 1'b0;
        m_hold = 1'b0;
        m_wrapped = 1'b0;
        cur.delete();
        m_line.delete();
    endtask

    task automatic model_update();
        m_acc = 1'b0;
        if (rst) return;
        if (!m_en) begin
            m_en = 1'b1;
            return;
        end
        if (m_hold) begin
            if (line_ack) m_hold = 1'b0;
            return;
        end
        if (!ch_valid) return;
        m_acc = 1'b1;
        if (ch_data == 8'h0D) return;
        if (ch_data == 8'h0A) begin
            m_line = cur;
            cur.delete();
            m_wrapped = 1'b0;
            m_hold = 1'b1;
            return;
        end
        cur.push_back(ch_data);
        src_chars++;
        if (cur.size() == LINE_LEN) begin
            m_line = cur;
            cur.delete();
            m_wrapped = 1'b1;
            m_hold = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                chk("ch_ready", 32'(ch_ready), 32'(m_en && !m_hold));
                chk("line_valid", 32'(line_valid), 32'(m_hold));
                if (m_hold) begin
                    chk("line_len", 32'(line_len), 32'(m_line.size()));
                    chk("line_wrapped", 32'(line_wrapped), 32'(m_wrapped));
                    chk("line_rule", 32'(line_rule), 32'(exp_rule_ch(m_line) != 8'h00));
                    chk("line_rule_ch", 32'(line_rule_ch), 32'(exp_rule_ch(m_line)));
                end
            end
        end
    end

    task automatic send_char(input logic [7:0] c);
        ch_valid = 1'b1;
        ch_data = c;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m_acc) return;
        end
        checks++;
        failures++;
        $display("FAIL send_timeout actual=not_accepted required=accepted char=%0h", c);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
        ch_valid = 1'b0;
    endtask

    task automatic read_at(input int a, output logic [7:0] d);
        rd_addr = LEN_W'(a);
        tick();
        d = rd_data;
    endtask

    task automatic read_line(input int dly);
        logic [7:0] d;
        int n;
        n = m_line.size();
        for (int a = 0; a <= n && a <= LINE_LEN; a++) begin
            read_at(a, d);
            chk("rd_data", 32'(d), (a < n) ? 32'(m_line[a]) : 32'h20);
        end
        rx_total += int'(line_len);
        line_no++;
        $display("line %0d len=%0d wrapped=%0d rule=%0d rule_ch=%02h", line_no, line_len,
                 line_wrapped, line_rule, line_rule_ch);
        repeat (dly) tick();
        line_ack = 1'b1;
        tick();
        line_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ch_ready"}, 32'(ch_ready), 32'h0);
        chk({tag, "_line_valid"}, 32'(line_valid), 32'h0);
        chk({tag, "_line_len"}, 32'(line_len), 32'h0);
        chk({tag, "_line_wrapped"}, 32'(line_wrapped), 32'h0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        chk({tag, "_line_rule"}, 32'(line_rule), 32'h0);
        chk({tag, "_line_rule_ch"}, 32'(line_rule_ch), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [39:0] hello;
        logic [7:0]  d;
        int          cycles;
        logic [7:0]  rule_exp;
        hello = "HELLO";

        #12;
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: HELLO with valid held
        send_str("HELLO\n");
        chk("hello_valid_lat", 32'(line_valid), 32'h1);
        chk("hello_len_lit", 32'(line_len), 32'd5);
        chk("hello_wrap_lit", 32'(line_wrapped), 32'h0);
        chk("hello_model_len", 32'(m_line.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            read_at(i, d);
            chk("hello_rd_lit", 32'(d), 32'(hello[39-8*i -: 8]));
        end
        read_at(5, d);
        chk("hello_pad_lit", 32'(d), 32'h20);
        read_line(1);

        // ack while filling must be ignored
        line_ack = 1'b1;
        tick();
        line_ack = 1'b0;
        tick();
        chk("ack_in_fill_ready", 32'(ch_ready), 32'h1);

        // 2: 80 x 'A' without LF
        for (int i = 0; i < LINE_LEN; i++) send_char(8'h41);
        ch_data = 8'h41;
        repeat (3) tick();
        chk("wrap_len_lit", 32'(line_len), 32'd76);
        chk("wrap_flag_lit", 32'(line_wrapped), 32'h1);
        chk("wrap_ready_lit", 32'(ch_ready), 32'h0);
        read_line(2);
        for (int i = 0; i < 4; i++) send_char(8'h41);
        send_str("\n");
        chk("tail_len_lit", 32'(line_len), 32'd4);
        chk("tail_wrap_lit", 32'(line_wrapped), 32'h0);
        read_line(0);

        // 3: empty line, CR dropped
        send_str("\n");
        chk("empty_len_lit", 32'(line_len), 32'd0);
        chk("empty_valid_lit", 32'(line_valid), 32'h1);
        read_line(0);
        send_str("AB\r\n");
        chk("cr_len_lit", 32'(line_len), 32'd2);
        read_line(3);

        // 4: rule lines
        for (int i = 0; i < LINE_LEN; i++) send_char(8'h2A);
        ch_valid = 1'b0;
`ifdef RULE_DETECT_EN
        rule_exp = 8'h2A;
`else
        rule_exp = 8'h00;
`endif
        chk("star_len_lit", 32'(line_len), 32'd76);
        chk("star_rule_lit", 32'(line_rule), 32'(rule_exp != 8'h00));
        chk("star_rule_ch_lit", 32'(line_rule_ch), 32'(rule_exp));
        read_line(0);
        send_str("***\n");
        chk("short_rule_lit", 32'(line_rule), 32'h0);
        read_line(0);
        send_str("---x---\n");
        chk("mixed_rule_lit", 32'(line_rule), 32'h0);
        read_line(1);
        send_str("--------\n");
        read_line(0);
        send_str("_______\n");
        read_line(0);

        // 5: reset mid-line
        for (int i = 0; i < 10; i++) send_char(8'h30 + 8'(i));
        ch_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #2;
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        send_str("OK\n");
        chk("ok_len_lit", 32'(line_len), 32'd2);
        read_line(0);

        // 6: random gaps and ack delays
        src_chars = 0;
        rx_total = 0;
        cycles = 0;
        for (int sent = 0; sent < 300 && cycles < 20000; cycles++) begin
            if (m_hold) begin
                ch_valid = 1'b0;
                read_line($urandom_range(0, 5));
            end else begin
                ch_valid = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 11))
                    0:       ch_data = 8'h0A;
                    1:       ch_data = 8'h0D;
                    default: ch_data = 8'h61 + 8'($urandom_range(0, 25));
                endcase
                tick();
                if (m_acc) sent++;
            end
        end
        if (m_hold) read_line(0);
        send_str("\n");
        read_line(0);
        chk("no_char_lost", 32'(rx_total), 32'(src_chars));

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
